// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks destination registers in EX/MEM/WB,
// raises decode stalls/flushes and selects EX operand forwarding paths.
module hz_match (
  input  logic [4:0] rs,
  input  logic       used,
  input  logic       v,
  input  logic [4:0] rd,
  output logic       hit
);
  assign hit = used & v & (rd == rs) & (rs != 5'd0);
endmodule

module hazard_scoreboard #(
  parameter int FORWARD = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_de,
  input  logic [4:0]       rs1_de,
  input  logic [4:0]       rs2_de,
  input  logic             rs1_used_de,
  input  logic             rs2_used_de,
  input  logic [4:0]       rd_de,
  input  logic             RuWr_de,
  input  logic [1:0]       RUDataWrSrc_de,
  input  logic             br_taken_ex,
  output logic             stall_de,
  output logic             flush_de,
  output logic             bubble_ex,
  output logic [1:0]       fwdA_ex,
  output logic [1:0]       fwdB_ex,
  output logic [CNT_W-1:0] stall_count
);
  // EX keeps its sources so forwarding can be resolved against MEM/WB.
  typedef struct packed {
    logic            v;
    logic [4:0]      rd;
    logic            ld;
    logic [1:0][4:0] rs;
    logic [1:0]      used;
  } ex_ent_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_ent_t;

  ex_ent_t         ex_q, ex_d;
  sb_ent_t         mem_q, wb_q;
  logic [1:0][4:0] rs_de;
  logic [1:0]      used_de;
  logic [1:0]      hit_ex, hit_mem, hit_fm, hit_fw;
  logic [1:0][1:0] fwd;
  logic            stall_raw;
  logic [CNT_W-1:0] cnt_q;

  assign rs_de   = {rs2_de, rs1_de};
  assign used_de = {rs2_used_de, rs1_used_de} & {2{valid_de}};

  for (genvar s = 0; s < 2; s++) begin : g_src
    hz_match u_de_ex  (.rs(rs_de[s]),   .used(used_de[s]),   .v(ex_q.v),  .rd(ex_q.rd),  .hit(hit_ex[s]));
    hz_match u_de_mem (.rs(rs_de[s]),   .used(used_de[s]),   .v(mem_q.v), .rd(mem_q.rd), .hit(hit_mem[s]));
    hz_match u_ex_mem (.rs(ex_q.rs[s]), .used(ex_q.used[s]), .v(mem_q.v), .rd(mem_q.rd), .hit(hit_fm[s]));
    hz_match u_ex_wb  (.rs(ex_q.rs[s]), .used(ex_q.used[s]), .v(wb_q.v),  .rd(wb_q.rd),  .hit(hit_fw[s]));
    // Built from flops only; a bubble carries used=0 and never forwards.
    assign fwd[s] = (FORWARD == 0) ? 2'b00 :
                    hit_fm[s]      ? 2'b01 :
                    hit_fw[s]      ? 2'b10 : 2'b00;
  end

  assign fwdA_ex = fwd[0];
  assign fwdB_ex = fwd[1];

  always_comb begin
    stall_raw = 1'b0;
    if (FORWARD != 0) stall_raw = (|hit_ex) & ex_q.ld;
    else              stall_raw = |(hit_ex | hit_mem);
  end

  assign stall_de  = valid_de & stall_raw & ~br_taken_ex;
  assign flush_de  = br_taken_ex;
  assign bubble_ex = stall_de | br_taken_ex;

  always_comb begin
    ex_d = '0;
    if (!bubble_ex) begin
      ex_d.v    = valid_de & RuWr_de & (rd_de != 5'd0);
      ex_d.rd   = rd_de;
      ex_d.ld   = (RUDataWrSrc_de == 2'b01);
      ex_d.rs   = rs_de;
      ex_d.used = used_de;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= '{v: ex_q.v, rd: ex_q.rd};
      wb_q  <= mem_q;
      if (stall_de && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: three scoreboard variants (forwarding, interlock, 2-bit counter) on shared stimulus.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst;
  logic       valid_de, rs1_used_de, rs2_used_de, RuWr_de, br_taken_ex;
  logic [4:0] rs1_de, rs2_de, rd_de;
  logic [1:0] RUDataWrSrc_de;

  logic        st1, fl1, bb1, st0, fl0, bb0, st2, fl2, bb2;
  logic [1:0]  fa1, fb1, fa0, fb0, fa2, fb2;
  logic [15:0] cnt1, cnt0;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.FORWARD(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .valid_de(valid_de), .rs1_de(rs1_de), .rs2_de(rs2_de),
    .rs1_used_de(rs1_used_de), .rs2_used_de(rs2_used_de), .rd_de(rd_de), .RuWr_de(RuWr_de),
    .RUDataWrSrc_de(RUDataWrSrc_de), .br_taken_ex(br_taken_ex), .stall_de(st1), .flush_de(fl1),
    .bubble_ex(bb1), .fwdA_ex(fa1), .fwdB_ex(fb1), .stall_count(cnt1));

  hazard_scoreboard #(.FORWARD(0), .CNT_W(16)) d0 (
    .clk(clk), .rst(rst), .valid_de(valid_de), .rs1_de(rs1_de), .rs2_de(rs2_de),
    .rs1_used_de(rs1_used_de), .rs2_used_de(rs2_used_de), .rd_de(rd_de), .RuWr_de(RuWr_de),
    .RUDataWrSrc_de(RUDataWrSrc_de), .br_taken_ex(br_taken_ex), .stall_de(st0), .flush_de(fl0),
    .bubble_ex(bb0), .fwdA_ex(fa0), .fwdB_ex(fb0), .stall_count(cnt0));

  hazard_scoreboard #(.FORWARD(1), .CNT_W(2)) d2 (
    .clk(clk), .rst(rst), .valid_de(valid_de), .rs1_de(rs1_de), .rs2_de(rs2_de),
    .rs1_used_de(rs1_used_de), .rs2_used_de(rs2_used_de), .rd_de(rd_de), .RuWr_de(RuWr_de),
    .RUDataWrSrc_de(RUDataWrSrc_de), .br_taken_ex(br_taken_ex), .stall_de(st2), .flush_de(fl2),
    .bubble_ex(bb2), .fwdA_ex(fa2), .fwdB_ex(fb2), .stall_count(cnt2));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Drive one decode-stage instruction at negedge; outputs settle 1ns later.
  task automatic de(input logic v, input logic [4:0] r1, input logic u1,
                    input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                    input logic wr, input logic [1:0] src, input logic br);
    @(negedge clk);
    valid_de = v; rs1_de = r1; rs1_used_de = u1; rs2_de = r2; rs2_used_de = u2;
    rd_de = rd; RuWr_de = wr; RUDataWrSrc_de = src; br_taken_ex = br;
    #1;
  endtask

  task automatic idle();
    de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_de = 1'b0; rs1_de = '0; rs2_de = '0; rs1_used_de = 1'b0; rs2_used_de = 1'b0;
    rd_de = '0; RuWr_de = 1'b0; RUDataWrSrc_de = 2'b00; br_taken_ex = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    check("rst_stall1", {15'd0, st1}, 16'd0);
    check("rst_stall0", {15'd0, st0}, 16'd0);
    check("rst_flush",  {15'd0, fl1}, 16'd0);
    check("rst_bubble", {15'd0, bb0}, 16'd0);
    check("rst_fwd",    {12'd0, fa1, fb1}, 16'd0);
    check("rst_cnt",    cnt1, 16'd0);

    // load-use with forwarding: one stall, then WB forward
    do_reset();
    de(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
    check("lu_lw_nostall", {15'd0, st1}, 16'd0);
    de(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'b00, 1'b0);
    check("lu_stall",  {15'd0, st1}, 16'd1);
    check("lu_bubble", {15'd0, bb1}, 16'd1);
    check("lu_flush",  {15'd0, fl1}, 16'd0);
    de(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'b00, 1'b0);
    check("lu_stall_1cyc", {15'd0, st1}, 16'd0);
    idle();
    check("lu_fwdA", {14'd0, fa1}, 16'd2);
    check("lu_fwdB", {14'd0, fb1}, 16'd0);
    check("lu_cnt",  cnt1, 16'd1);

    // ALU back-to-back: MEM forward on both operands
    do_reset();
    de(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 2'b00, 1'b0);
    de(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 2'b00, 1'b0);
    check("alu_nostall", {15'd0, st1}, 16'd0);
    idle();
    check("alu_fwdA", {14'd0, fa1}, 16'd1);
    check("alu_fwdB", {14'd0, fb1}, 16'd1);
    check("alu_cnt",  cnt1, 16'd0);

    // full interlock: two stall cycles, never forwards
    do_reset();
    de(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 2'b00, 1'b0);
    de(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 2'b00, 1'b0);
    check("il_stall_c1", {15'd0, st0}, 16'd1);
    de(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 2'b00, 1'b0);
    check("il_stall_c2", {15'd0, st0}, 16'd1);
    de(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 2'b00, 1'b0);
    check("il_stall_c3", {15'd0, st0}, 16'd0);
    idle();
    check("il_fwdA", {14'd0, fa0}, 16'd0);
    check("il_cnt",  cnt0, 16'd2);

    // taken branch overrides a load-use hazard and kills decode
    do_reset();
    de(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
    de(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'b00, 1'b1);
    check("br_stall",  {15'd0, st1}, 16'd0);
    check("br_flush",  {15'd0, fl1}, 16'd1);
    check("br_bubble", {15'd0, bb1}, 16'd1);
    check("br_stall0", {15'd0, st0}, 16'd0);
    de(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'b00, 1'b0);
    check("br_ex_empty", {15'd0, st0}, 16'd0);
    check("br_flush_off", {15'd0, fl0}, 16'd0);
    check("br_cnt", cnt1, 16'd0);

    // x0 and unused sources never create hazards
    do_reset();
    de(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 2'b01, 1'b0);
    de(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 2'b00, 1'b0);
    check("x0_stall0", {15'd0, st0}, 16'd0);
    de(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 2'b01, 1'b0);
    check("x0_fwd", {12'd0, fa1, fb1}, 16'd0);
    de(1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd4, 1'b1, 2'b00, 1'b0);
    check("unused_stall0", {15'd0, st0}, 16'd0);
    check("unused_stall1", {15'd0, st1}, 16'd0);
    idle();
    check("unused_fwd", {12'd0, fa1, fb1}, 16'd0);

    // 2-bit counter saturates after five stalls
    do_reset();
    for (int i = 0; i < 5; i++) begin
      de(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
      de(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'b00, 1'b0);
      if (i == 2) begin
        idle();
        check("sat_cnt3", {14'd0, cnt2}, 16'd3);
      end
    end
    idle();
    check("sat_cnt", {14'd0, cnt2}, 16'd3);
    check("sat_cnt16", cnt1, 16'd5);
    do_reset();
    check("sat_rst", {14'd0, cnt2}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter FORWARD, default 1: 1 = EX/MEM forwarding present, so only load-use stalls; 0 = full interlock.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 valid_de  input  1  decode stage holds a real instruction.
REQ-006 rs1_de, rs2_de  input  5 each  source register indices in decode.
REQ-007 rs1_used_de, rs2_used_de  input  1 each  the corresponding source is actually read.
REQ-008 rd_de  input  5  destination index in decode.
REQ-009 RuWr_de  input  1  decode instruction writes the register unit.
REQ-010 RUDataWrSrc_de  input  2  write-back source; 2'b01 = data memory (load).
REQ-011 br_taken_ex  input  1  branch/jump resolved taken in EX.
REQ-012 stall_de  output  1  hold PC and the fetch/decode register this cycle.
REQ-013 flush_de  output  1  kill the instruction in decode.
REQ-014 bubble_ex  output  1  load zeros/NOP into the decode-to-execute control register next edge.
REQ-015 fwdA_ex, fwdB_ex  output  2 each  operand select for EX: 00 register unit, 01 from MEM, 10 from WB.
REQ-016 stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-017 Internal scoreboard of three entries (EX, MEM, WB), each holding {v, rd, ld} plus stored rs1/rs2/used bits for the EX entry.
REQ-018 Entry write condition: v = valid_de & RuWr_de & (rd_de != 0); ld = (RUDataWrSrc_de == 2'b01).
REQ-019 Each edge: WB <= MEM and MEM <= EX.
REQ-020 Each edge, EX <= decode entry when (!stall_de & !br_taken_ex); otherwise EX <= bubble (v = 0).
REQ-021 Source match: srcX hits stage S when rsX_used_de & S.v & (S.rd == rsX_de) & (rsX_de != 0).
REQ-022 FORWARD=0: stall_de = valid_de & (any source hits EX or MEM); WB hits do not stall, since the register unit writes through.
REQ-023 FORWARD=1: stall_de = valid_de & (any source hits EX with EX.ld = 1), i.e. a one-cycle load-use stall.
REQ-024 Stalls are combinational from the current inputs and scoreboard state (zero-cycle latency).
REQ-025 bubble_ex = stall_de | br_taken_ex.
REQ-026 flush_de = br_taken_ex.
REQ-027 When br_taken_ex = 1 it has priority: stall_de is forced to 0 in the same cycle.
REQ-028 fwdA_ex/fwdB_ex are registered versions of the EX entry's sources matched against MEM/WB.
REQ-029 Forward-select priority: MEM (01) over WB (10); 00 when there is no hit, when FORWARD = 0, or when the EX entry is a bubble.
REQ-030 stall_count increments by 1 on each edge with stall_de = 1, saturates at all-ones, and does not wrap.
REQ-031 A stall lasts exactly 1 cycle for load-use (FORWARD=1) and at most 2 cycles for FORWARD=0.
REQ-032 Register index 0 never causes a stall or a forward.

Reset
REQ-033 While rst = 1 at an edge: all scoreboard entries v = 0, fwdA_ex = fwdB_ex = 00, stall_count = 0.
REQ-034 During and after reset: stall_de, flush_de, bubble_ex = 0 until a valid_de hazard appears.
REQ-035 Reset mid-stall clears the pending hazard; the held instruction re-enters as if it were new.

Verification
REQ-036 FORWARD=1, lw x5 then add x6,x5,x1 back-to-back -> stall_de = 1 for exactly 1 cycle, then fwdA_ex = 10 when the add reaches EX, and stall_count = 1.
REQ-037 FORWARD=1, add x5 then sub x7,x5,x5 -> no stall, and fwdA_ex = fwdB_ex = 01 in the sub's EX cycle.
REQ-038 FORWARD=0, add x5 then or x8,x5,x0 -> stall_de high for 2 cycles, and fwdA_ex stays 00.
REQ-039 Load-use hazard with br_taken_ex = 1 in the same cycle -> stall_de = 0, flush_de = 1, bubble_ex = 1, and the next EX entry v = 0.
REQ-040 Writes and reads to x0, or rs_used = 0 -> no stall and no forwarding.
REQ-041 CNT_W = 2 with 5 consecutive stall cycles -> stall_count = 3 (saturated); rst pulse -> 0.
